// File: rtl/conv_window_ctrl_if.sv
// Pixel-stream / window handshake bundle between conv_window_ctrl and its neighbours.
// stall_cnt is present only when CONV_WINDOW_CTRL_PERF_EN is defined.
interface conv_window_ctrl_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic             shift_ce;
    logic             win_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_row;
    logic [CNT_W-1:0] out_col;
    logic             busy;
    logic             done;
`ifdef CONV_WINDOW_CTRL_PERF_EN
    logic [15:0]      stall_cnt;

    modport master (output start, in_valid, out_ready,
                    input  in_ready, shift_ce, win_valid, out_row, out_col, busy, done, stall_cnt);
    modport slave  (input  start, in_valid, out_ready,
                    output in_ready, shift_ce, win_valid, out_row, out_col, busy, done, stall_cnt);
`else
    modport master (output start, in_valid, out_ready,
                    input  in_ready, shift_ce, win_valid, out_row, out_col, busy, done);
    modport slave  (input  start, in_valid, out_ready,
                    output in_ready, shift_ce, win_valid, out_row, out_col, busy, done);
`endif
endinterface

// File: rtl/conv_window_ctrl.sv
// KxK sliding-window line-buffer sequencer: paces the raster stream, drives the shift enable
// and flags stride-aligned windows. Optional stall counter under CONV_WINDOW_CTRL_PERF_EN.
module conv_window_ctrl #(
    parameter int unsigned KERNEL = 3,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned STRIDE = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    conv_window_ctrl_if.slave bus
);
    localparam int unsigned OUT_COLS = (IMG_W - KERNEL) / STRIDE + 1;
    localparam logic [CNT_W-1:0] K_M1_C      = CNT_W'(KERNEL - 1);
    localparam logic [CNT_W-1:0] LAST_COL_C  = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] LAST_ROW_C  = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] LAST_WCOL_C = CNT_W'(OUT_COLS - 1);
    localparam logic [CNT_W-1:0] STRIDE_M1_C = CNT_W'(STRIDE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
    logic [CNT_W-1:0] col_ph_q, col_ph_d, row_ph_q, row_ph_d;
    logic [CNT_W-1:0] win_col_q, win_col_d, win_row_q, win_row_d;
    logic [CNT_W-1:0] out_col_q, out_col_d, out_row_q, out_row_d;
    logic             win_valid_q, win_valid_d, busy_q, busy_d, done_q, done_d;
    logic             in_ready_c, accept_c, hit_c, last_col_c, last_row_c, start_c;
`ifdef CONV_WINDOW_CTRL_PERF_EN
    logic [15:0]      stall_cnt_q, stall_cnt_d;
`endif

    // Stride phase: position modulo STRIDE once past the first K-1 pixels of a line.
    function automatic logic [CNT_W-1:0] ph_step(input logic [CNT_W-1:0] ph);
        return (ph == STRIDE_M1_C) ? '0 : ph + CNT_W'(1);
    endfunction

    always_comb begin
        start_c    = (state_q == ST_IDLE) && bus.start;
        in_ready_c = (state_q == ST_RUN) && !(win_valid_q && !bus.out_ready);
        accept_c   = bus.in_valid && in_ready_c;
        last_col_c = (col_q == LAST_COL_C);
        last_row_c = (row_q == LAST_ROW_C);
        hit_c      = accept_c && (row_q >= K_M1_C) && (col_q >= K_M1_C)
                     && (row_ph_q == '0) && (col_ph_q == '0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_RUN;
            ST_RUN:   if (accept_c && last_col_c && last_row_c) state_d = ST_FLUSH;
            ST_FLUSH: if (!win_valid_q || bus.out_ready) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        col_ph_d  = col_ph_q;
        row_ph_d  = row_ph_q;
        win_col_d = win_col_q;
        win_row_d = win_row_q;
        out_col_d = out_col_q;
        out_row_d = out_row_q;
        if (start_c) begin
            col_d     = '0;
            row_d     = '0;
            col_ph_d  = '0;
            row_ph_d  = '0;
            win_col_d = '0;
            win_row_d = '0;
        end
        if (accept_c) begin
            if (last_col_c) begin
                col_d    = '0;
                col_ph_d = '0;
                row_d    = last_row_c ? '0 : row_q + CNT_W'(1);
                row_ph_d = ((row_q >= K_M1_C) && !last_row_c) ? ph_step(row_ph_q) : '0;
            end else begin
                col_d    = col_q + CNT_W'(1);
                col_ph_d = (col_q >= K_M1_C) ? ph_step(col_ph_q) : '0;
            end
        end
        // Latch coordinates of the new window and advance the output-map position
        if (hit_c) begin
            out_col_d = win_col_q;
            out_row_d = win_row_q;
            if (win_col_q == LAST_WCOL_C) begin
                win_col_d = '0;
                win_row_d = win_row_q + CNT_W'(1);
            end else begin
                win_col_d = win_col_q + CNT_W'(1);
            end
        end
        win_valid_d = hit_c || (win_valid_q && !bus.out_ready);
        busy_d      = (state_d == ST_RUN) || (state_d == ST_FLUSH);
        done_d      = (state_d == ST_DONE);
`ifdef CONV_WINDOW_CTRL_PERF_EN
        stall_cnt_d = stall_cnt_q;
        if (start_c) begin
            stall_cnt_d = '0;
        end else if (((state_q == ST_RUN) || (state_q == ST_FLUSH)) && win_valid_q
                     && !bus.out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            col_ph_q    <= '0;
            row_ph_q    <= '0;
            win_col_q   <= '0;
            win_row_q   <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            win_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef CONV_WINDOW_CTRL_PERF_EN
            stall_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            col_ph_q    <= col_ph_d;
            row_ph_q    <= row_ph_d;
            win_col_q   <= win_col_d;
            win_row_q   <= win_row_d;
            out_col_q   <= out_col_d;
            out_row_q   <= out_row_d;
            win_valid_q <= win_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef CONV_WINDOW_CTRL_PERF_EN
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

    always_comb begin
        bus.in_ready  = in_ready_c;
        bus.shift_ce  = accept_c;
        bus.win_valid = win_valid_q;
        bus.out_row   = out_row_q;
        bus.out_col   = out_col_q;
        bus.busy      = busy_q;
        bus.done      = done_q;
`ifdef CONV_WINDOW_CTRL_PERF_EN
        bus.stall_cnt = stall_cnt_q;
`endif
    end
endmodule

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
Sequencer for the KxK sliding-window line buffer built from the team's shift_register chains in the conv engine.
- Accepts a raster pixel stream through a valid/ready handshake.
- Drives the common shift enable of the line-buffer shift registers.
- Tracks row/column position and flags the cycles when the buffer holds a complete, stride-aligned window for the MAC array.
- Applies downstream backpressure to the input stream and reports frame completion.

Parameters:
KERNEL, 3, window size K (K x K), K >= 2
IMG_W, 8, image width in pixels, IMG_W >= KERNEL
IMG_H, 8, image height in pixels, IMG_H >= KERNEL
STRIDE, 1, window step in both directions, 1..KERNEL
CNT_W, 8, width of row/col/position counters, 2^CNT_W > max(IMG_W, IMG_H)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle frame start; honoured only in IDLE
in_valid  input  1  upstream pixel valid
in_ready  output  1  controller accepts a pixel this cycle
shift_ce  output  1  shift enable to all line-buffer shift registers; equals in_valid & in_ready
win_valid  output  1  full, stride-aligned window is present in the buffer
out_ready  input  1  downstream consumed the window (handshake with win_valid)
out_row  output  CNT_W  output-feature-map row of the current window
out_col  output  CNT_W  output-feature-map column of the current window
busy  output  1  high in RUN and FLUSH
done  output  1  one-cycle pulse after the last window handshake

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0. Row/col/stride/position counters 0.
- States:
  - IDLE: in_ready=0. start=1 -> RUN, clears all counters.
  - RUN: accepts pixels.
  - FLUSH: entered when pixel (IMG_H-1, IMG_W-1) is accepted; waits for the final window handshake.
  - DONE: done=1 for one cycle, then -> IDLE.
- Input acceptance:
  - in_ready = (state==RUN) & ~(win_valid & ~out_ready).
  - A pixel is accepted when in_valid & in_ready.
  - col increments per accepted pixel and wraps at IMG_W-1 to 0, incrementing row.
- Window detection, for an accepted pixel at (r,c):
  - Conditions: r >= K-1, c >= K-1, (r-(K-1)) mod STRIDE == 0, and (c-(K-1)) mod STRIDE == 0.
  - Modulo is implemented with wrap counters; no dividers.
  - If all hold, win_valid rises the next cycle. Latency is 1 cycle from the accepting edge.
  - out_row/out_col are presented with win_valid and hold stable while win_valid=1.
- Window handshake:
  - win_valid stays high until a cycle with out_ready=1, then clears, unless a new window is flagged at that same edge.
  - A window pixel accepted in the same cycle as the handshake re-asserts win_valid with new coordinates.
- out_col/out_row advance: out_col runs 0..((IMG_W-K)/STRIDE); out_row increments when out_col wraps.
- FLUSH: in_ready=0. If win_valid=0, or win_valid & out_ready, go to DONE next cycle.
- Ignored inputs:
  - start is ignored outside IDLE.
  - in_valid is ignored outside RUN; shift_ce stays 0 there.
- Pixel rows/columns past the last full stride position feed the buffer but never raise win_valid.
- Reset mid-frame: immediate return to IDLE, all outputs 0; no done pulse.

Optional Feature:
Macro CONV_WINDOW_CTRL_PERF_EN.
- When defined: adds output stall_cnt[15:0].
  - Counts cycles in RUN/FLUSH with win_valid=1 & out_ready=0.
  - Saturates at 16'hFFFF; clears on start accepted in IDLE and on reset.
  - Holds its value in IDLE.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- K=3, IMG 4x4, S=1, out_ready=1, continuous in_valid -> 16 shift_ce pulses; exactly 4 win_valid cycles.
  - Windows (0,0),(0,1),(1,0),(1,1).
  - First win_valid the cycle after pixel index 10 is accepted.
  - done pulses 1 cycle after the last window; busy low afterwards.
- K=3, IMG 5x5, S=2 -> 4 windows, after pixels (2,2),(2,4),(4,2),(4,4), coordinates (0,0),(0,1),(1,0),(1,1); no window after (3,x) or (x,3).
- Backpressure, 4x4 S=1: hold out_ready=0 for 5 cycles at the first window.
  - in_ready=0 and shift_ce=0 for those cycles; win_valid and out_row/out_col stable at (0,0).
  - Stream resumes after out_ready=1; PERF build: stall_cnt=5.
- Last window stalled in FLUSH (out_ready=0 for 3 cycles) -> no done until the handshake; done exactly 1 cycle after it.
- Assert rst_n=0 after 7 pixels of a frame -> all outputs 0 asynchronously.
  - Fresh start afterwards produces the full 4-window sequence from (0,0).
- start pulsed during RUN, and in_valid pulsed during IDLE -> no counter change, no shift_ce, frame result unchanged.
